// File: rtl/coproc_instr_scheduler.sv
// Instruction queue and issue sequencer for the image coprocessor.
// Host words are buffered in a circular FIFO and issued one at a time
// over a four-phase start/done handshake. NOP opcodes are dropped and
// every handshake phase is guarded by a watchdog.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a FIFO entry; pops the head into instr_q
// LOAD    | decode instr_q; drop NOPs, otherwise latch cop_instr
// ISSUE   | cop_start high, waiting for cop_done rise (or watchdog)
// RELEASE | cop_start low, waiting for cop_done fall (or watchdog)

module coproc_instr_scheduler #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [25:0]              host_instr,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [25:0]              cop_instr,
    output logic                     cop_start,
    input  logic                     cop_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_timeout,
    input  logic                     err_clr,
    output logic [15:0]              issued
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [2:0]    OP_NOP  = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_RELEASE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [25:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [25:0]     instr_q;
    logic [WW-1:0]   wd;

    logic            push;
    logic            pop;
    logic            load_cop;
    logic            start_nxt;
    logic            wd_clr;
    logic            wd_inc;
    logic            fire;
    logic            done_ok;
    logic            wd_hit;

    assign host_ready = (count < FULL);
    assign push       = host_valid & host_ready;
    assign fifo_count = count;
    assign busy       = (state != S_IDLE) || (count != '0);
    assign wd_hit     = (wd == WD_LAST);

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_instr;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_cop  = 1'b0;
        start_nxt = 1'b0;
        wd_clr    = 1'b0;
        wd_inc    = 1'b0;
        fire      = 1'b0;
        done_ok   = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (instr_q[2:0] == OP_NOP) begin
                    state_nxt = S_IDLE;
                end else begin
                    load_cop  = 1'b1;
                    start_nxt = 1'b1;
                    wd_clr    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cop_done) begin
                    done_ok   = 1'b1;
                    wd_clr    = 1'b1;
                    state_nxt = S_RELEASE;
                end else if (wd_hit) begin
                    fire      = 1'b1;
                    wd_clr    = 1'b1;
                    state_nxt = S_RELEASE;
                end else begin
                    start_nxt = 1'b1;
                    wd_inc    = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!cop_done) begin
                    state_nxt = S_IDLE;
                end else if (wd_hit) begin
                    fire      = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    wd_inc    = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO pointers/occupancy, registered handshake outputs, watchdog and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            instr_q     <= '0;
            cop_instr   <= '0;
            cop_start   <= 1'b0;
            wd          <= '0;
            err_timeout <= 1'b0;
            issued      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                instr_q <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (load_cop) begin
                cop_instr <= instr_q;
            end
            cop_start <= start_nxt;
            if (wd_clr) begin
                wd <= '0;
            end else if (wd_inc) begin
                wd <= wd + WW'(1);
            end
            // a timeout in the same cycle as err_clr keeps the flag set
            if (fire) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
            if (done_ok) begin
                issued <= issued + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_coproc_instr_scheduler.sv
// Directed bench for coproc_instr_scheduler. Inputs change and outputs are
// sampled 2 time units after each rising edge.

module tb_coproc_instr_scheduler;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    localparam logic [25:0] W_SINGLE = 26'h0000041;
    localparam logic [25:0] W_NOP_A  = 26'h0123450;
    localparam logic [25:0] W_OP_B   = 26'h2AAAAA2;
    localparam logic [25:0] W_NOP_C  = 26'h1555558;
    localparam logic [25:0] W_BLK    = 26'h0000101;
    localparam logic [25:0] W_TO_A   = 26'h0000007;
    localparam logic [25:0] W_TO_B   = 26'h0000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [25:0] host_instr;
    logic        host_valid;
    logic        host_ready;
    logic [25:0] cop_instr;
    logic        cop_start;
    logic        cop_done;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        err_timeout;
    logic        err_clr;
    logic [15:0] issued;

    int n_assert = 0;
    int n_fail   = 0;

    logic [25:0] fill_w [9];
    logic [25:0] got [$];

    coproc_instr_scheduler #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_instr  (host_instr),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .cop_instr   (cop_instr),
        .cop_start   (cop_start),
        .cop_done    (cop_done),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
        .issued      (issued)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int          cnt;
        int          max_cnt;
        logic        prev;
        logic [25:0] g;

        rst_n      = 1'b0;
        host_valid = 1'b0;
        host_instr = '0;
        cop_done   = 1'b0;
        err_clr    = 1'b0;
        for (int i = 0; i < 9; i++) begin
            fill_w[i] = 26'((i + 1) * 256 + 5);
        end

        // reset values
        step(2);
        chk("rst_cop_start", 32'(cop_start), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd1);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_issued", 32'(issued), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_cop_instr", 32'(cop_instr), 32'd0);
        rst_n = 1'b1;
        step(1);

        // single issue
        host_valid = 1'b1;
        host_instr = W_SINGLE;
        step(1);
        host_valid = 1'b0;
        chk("t1_count_after_push", 32'(fifo_count), 32'd1);
        chk("t1_start_at_push", 32'(cop_start), 32'd0);
        step(1);
        chk("t1_start_at_load", 32'(cop_start), 32'd0);
        chk("t1_busy_at_load", 32'(busy), 32'd1);
        step(1);
        chk("t1_start_2_after_push", 32'(cop_start), 32'd1);
        chk("t1_instr_a", 32'(cop_instr), 32'(W_SINGLE));
        step(2);
        chk("t1_start_held", 32'(cop_start), 32'd1);
        chk("t1_instr_b", 32'(cop_instr), 32'(W_SINGLE));
        step(1);
        chk("t1_start_held2", 32'(cop_start), 32'd1);
        chk("t1_issued_before_done", 32'(issued), 32'd0);
        cop_done = 1'b1;
        step(1);
        chk("t1_start_dropped", 32'(cop_start), 32'd0);
        chk("t1_issued", 32'(issued), 32'd1);
        chk("t1_busy_release", 32'(busy), 32'd1);
        step(1);
        chk("t1_busy_release2", 32'(busy), 32'd1);
        cop_done = 1'b0;
        step(1);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        chk("t1_instr_after", 32'(cop_instr), 32'(W_SINGLE));

        // NOP filter
        host_valid = 1'b1;
        host_instr = W_NOP_A;
        step(1);
        host_instr = W_OP_B;
        step(1);
        host_instr = W_NOP_C;
        step(1);
        host_valid = 1'b0;
        cnt  = 0;
        prev = 1'b0;
        got.delete();
        for (int c = 0; c < 20; c++) begin
            if (cop_start && !prev) begin
                cnt++;
                got.push_back(cop_instr);
            end
            prev     = cop_start;
            cop_done = cop_start;
            step(1);
        end
        cop_done = 1'b0;
        g = (got.size() > 0) ? got[0] : 26'h3FFFFFF;
        chk("nop_pulses", 32'(cnt), 32'd1);
        chk("nop_pulse_word", 32'(g), 32'(W_OP_B));
        chk("nop_issued", 32'(issued), 32'd2);
        chk("nop_busy_end", 32'(busy), 32'd0);

        // fill and drain behind a stalled blocker
        host_valid = 1'b1;
        host_instr = W_BLK;
        step(1);
        host_valid = 1'b0;
        step(2);
        chk("fill_blk_start", 32'(cop_start), 32'd1);
        chk("fill_blk_instr", 32'(cop_instr), 32'(W_BLK));
        max_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill_ready_%0d", i), 32'(host_ready), 32'd1);
            host_valid = 1'b1;
            host_instr = fill_w[i];
            step(1);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        chk("fill_count_full", 32'(fifo_count), 32'd8);
        chk("fill_ready_low", 32'(host_ready), 32'd0);
        host_instr = fill_w[8];
        step(2);
        chk("fill_9th_held_count", 32'(fifo_count), 32'd8);
        chk("fill_9th_held_ready", 32'(host_ready), 32'd0);
        cop_done = 1'b1;
        step(1);
        chk("fill_blk_done", 32'(cop_start), 32'd0);
        cop_done = 1'b0;
        step(1);
        chk("fill_idle_still_full", 32'(fifo_count), 32'd8);
        chk("fill_idle_ready_low", 32'(host_ready), 32'd0);
        step(1);
        chk("fill_after_pop_count", 32'(fifo_count), 32'd7);
        chk("fill_after_pop_ready", 32'(host_ready), 32'd1);
        step(1);
        host_valid = 1'b0;
        chk("fill_9th_accepted", 32'(fifo_count), 32'd8);
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        got.delete();
        prev = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (cop_start && !prev) got.push_back(cop_instr);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            prev     = cop_start;
            cop_done = cop_start;
            step(1);
        end
        cop_done = 1'b0;
        chk("drain_num_issued", 32'(got.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            g = (i < got.size()) ? got[i] : 26'h3FFFFFF;
            chk($sformatf("drain_order_%0d", i), 32'(g), 32'(fill_w[i]));
        end
        chk("drain_max_count", 32'(max_cnt), 32'd8);
        chk("drain_issued", 32'(issued), 32'd12);
        chk("drain_busy_end", 32'(busy), 32'd0);
        chk("drain_no_err", 32'(err_timeout), 32'd0);

        // watchdog timeout
        host_valid = 1'b1;
        host_instr = W_TO_A;
        step(1);
        host_instr = W_TO_B;
        step(1);
        host_valid = 1'b0;
        step(1);
        chk("to_start_rise", 32'(cop_start), 32'd1);
        cnt = 1;
        for (int c = 0; c < 40 && cop_start; c++) begin
            step(1);
            if (cop_start) cnt++;
        end
        chk("to_start_width", 32'(cnt), 32'd16);
        chk("to_err_set", 32'(err_timeout), 32'd1);
        chk("to_issued_unchanged", 32'(issued), 32'd12);
        for (int c = 0; c < 10 && !cop_start; c++) begin
            step(1);
        end
        chk("to_next_start", 32'(cop_start), 32'd1);
        chk("to_next_instr", 32'(cop_instr), 32'(W_TO_B));
        cop_done = 1'b1;
        step(1);
        cop_done = 1'b0;
        step(1);
        chk("to_next_issued", 32'(issued), 32'd13);
        chk("to_err_sticky", 32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("to_err_cleared", 32'(err_timeout), 32'd0);

        // reset mid-handshake with three entries queued
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1;
            host_instr = fill_w[i];
            step(1);
        end
        host_valid = 1'b0;
        chk("mid_start_before", 32'(cop_start), 32'd1);
        chk("mid_count_before", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("mid_start_after", 32'(cop_start), 32'd0);
        chk("mid_count_after", 32'(fifo_count), 32'd0);
        chk("mid_issued_after", 32'(issued), 32'd0);
        chk("mid_ready_after", 32'(host_ready), 32'd1);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (cop_start) cnt++;
            cop_done = cop_start;
            step(1);
        end
        cop_done = 1'b0;
        chk("mid_no_issue", 32'(cnt), 32'd0);
        chk("mid_issued_final", 32'(issued), 32'd0);
        chk("mid_busy_final", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/coproc_instr_scheduler.md
# coproc_instr_scheduler

Instruction queue and issue sequencer between the host instruction bus and the image coprocessor. It buffers 26-bit coprocessor instructions written by the host and issues them one at a time through a four-phase start/done handshake. It drops NOP opcodes and guards every issued instruction with a watchdog timeout. It sits beside the coprocessor in the top level, driving its `instruction`/`flag_in` pair and consuming its `flag_out`.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `TIMEOUT`, 1_000_000: maximum cycles to wait for done rise or done fall before the watchdog fires.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `host_instr` in 26: instruction word; bits [2:0] are the opcode.
- `host_valid` in 1: host offers `host_instr` this cycle.
- `host_ready` out 1: FIFO can accept; equals `count < DEPTH`.
- `cop_instr` out 26: instruction to the coprocessor; held stable while `cop_start` is high.
- `cop_start` out 1: issue strobe to coprocessor `flag_in`.
- `cop_done` in 1: coprocessor `flag_out`.
- `busy` out 1: high when the FSM is not IDLE or the FIFO is non-empty.
- `fifo_count` out $clog2(DEPTH)+1: current occupancy.
- `err_timeout` out 1: sticky watchdog flag.
- `err_clr` in 1: clears `err_timeout`.
- `issued` out 16: count of completed handshakes; wraps at 65535 to 0.

## Operation
- **FIFO:** circular buffer with wr_ptr, rd_ptr and count.
  - Push when `host_valid & host_ready`.
  - Pop only from the IDLE state.
  - A push and a pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, LOAD, ISSUE, RELEASE.
  - **IDLE:** if count != 0, pop the head into `instr_q` and go to LOAD; otherwise stay.
  - **LOAD:**
    - If `instr_q[2:0] == 3'b000` (NOP), return to IDLE without issuing; `issued` is unchanged.
    - Otherwise go to ISSUE with `cop_start` set to 1 and the watchdog cleared.
  - **ISSUE:**
    - `cop_start` = 1 and `cop_instr` = `instr_q`.
    - On `cop_done` = 1: drop `cop_start`, increment `issued`, go to RELEASE.
    - If the watchdog reaches TIMEOUT: drop `cop_start`, set `err_timeout`, go to RELEASE; `issued` is not incremented.
  - **RELEASE:**
    - `cop_start` = 0.
    - Wait for `cop_done` = 0, then go to IDLE.
    - The watchdog restarts on entry; on timeout, set `err_timeout` and go to IDLE anyway.
- **Handshake rules:** `cop_instr` changes only in LOAD. If `cop_done` is already high on entering ISSUE, it is accepted that same cycle.
- **Error flag:**
  - `err_timeout` is cleared by `err_clr` unless a new timeout fires in the same cycle; set wins.
  - The FIFO keeps draining while `err_timeout` is set.
- **Reset values (while `rst_n` = 0 at an edge):**
  - All outputs 0, except `host_ready` = 1.
  - FIFO emptied, pointers 0, FSM in IDLE, `instr_q` = 0, `issued` = 0, watchdog 0.
  - Reset mid-handshake drops `cop_start` on the next edge; the in-flight instruction is lost.

## Timing
- **Push to start:** a push accepted at edge N gives count = 1 after N. IDLE pops at edge N+1 (LOAD). `cop_start` is high after edge N+2.
- **Back-to-back throughput:** with `cop_done` responding in 1 cycle and falling in 1 cycle, one instruction per 4 cycles.
- **NOP cost:** 2 cycles (IDLE→LOAD→IDLE); a NOP never touches `cop_start`.
- **Flow control:** `host_ready` is combinational from count. When full, a pop at edge N raises `host_ready` after N, and the push is accepted at N+1.
- **Watchdog:** fires on the cycle the counter equals TIMEOUT−1. `cop_start` is low after the next edge.
- **Registered outputs:** `cop_start`, `cop_instr` and `err_timeout` come straight from flops, with no combinational path from `cop_done`.

## Test plan
- **Single issue.** Reset, push opcode 3'b001 word 0x0000041, `cop_done` model responds 3 cycles after start and falls 2 cycles after start drops. Required:
  - `cop_start` high exactly 2 cycles after the push;
  - `cop_instr` = 0x0000041 throughout;
  - `issued` = 1;
  - `busy` falls after RELEASE→IDLE.
- **Fill and drain.** Push 9 words back-to-back with the coprocessor stalled. Required:
  - `host_ready` drops after 8 accepted words;
  - the 9th is held until the first pop, then accepted;
  - issue order matches push order;
  - `fifo_count` never exceeds 8.
- **NOP filter.** Push NOP, op 3'b010, NOP. Required: exactly one `cop_start` pulse, carrying the 3'b010 word; `issued` = 1.
- **Timeout.** TIMEOUT = 16, `cop_done` tied 0, push one op. Required:
  - `cop_start` drops 16 cycles after rising;
  - `err_timeout` = 1 and `issued` = 0;
  - the next queued op is still issued;
  - `err_clr` pulse clears the flag.
- **Reset mid-handshake.** Assert `rst_n` = 0 for 1 cycle during ISSUE with 3 entries queued. Required:
  - next cycle `cop_start` = 0, `fifo_count` = 0, `issued` = 0, `host_ready` = 1;
  - no further issues occur.
